// File: rtl/wb_block_master_if.sv
// Signal bundle for wb_block_master: local command/stream side plus the Wishbone master bus.
// The master modport is the block's view; the slave modport is the view of whatever drives it.
interface wb_block_master_if #(
    parameter int unsigned AW = 3,
    parameter int unsigned DW = 32,
    parameter int unsigned LW = 3
);
    // Command
    logic          START_I;
    logic          WRITE_I;
    logic [AW-1:0] BASE_I;
    logic [LW-1:0] LEN_I;
    logic          BUSY_O;
    logic          DONE_O;
    logic          ERR_O;

    // Handshakes: a write beat moves when WR_VLD_I is high and WR_RDY_O pulses in the same
    // cycle; RD_VLD_O is a one-cycle pulse with no back-pressure; a Wishbone beat completes
    // on the cycle where STB_O and ACK_I are both high.
    logic [DW-1:0] WR_DAT_I;
    logic          WR_VLD_I;
    logic          WR_RDY_O;
    logic [DW-1:0] RD_DAT_O;
    logic          RD_VLD_O;

    // Wishbone
    logic [AW-1:0] ADR_O;
    logic [DW-1:0] DAT_O;
    logic [DW-1:0] DAT_I;
    logic          WE_O;
    logic          STB_O;
    logic          CYC_O;
    logic          ACK_I;

    modport master (
        input  START_I, WRITE_I, BASE_I, LEN_I, WR_DAT_I, WR_VLD_I, DAT_I, ACK_I,
        output BUSY_O, DONE_O, ERR_O, WR_RDY_O, RD_DAT_O, RD_VLD_O,
        output ADR_O, DAT_O, WE_O, STB_O, CYC_O
    );

    modport slave (
        output START_I, WRITE_I, BASE_I, LEN_I, WR_DAT_I, WR_VLD_I, DAT_I, ACK_I,
        input  BUSY_O, DONE_O, ERR_O, WR_RDY_O, RD_DAT_O, RD_VLD_O,
        input  ADR_O, DAT_O, WE_O, STB_O, CYC_O
    );
endinterface

// File: rtl/wb_block_master.sv
// Wishbone classic-cycle master running address-incrementing block reads/writes.
// Optional ACK watchdog enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_block_master #(
    parameter int unsigned AW  = 3,
    parameter int unsigned DW  = 32,
    parameter int unsigned LW  = 3,
    parameter int unsigned TMO = 15
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    wb_block_master_if.master bus,
    output logic [2:0]        DBG_STATE_O
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e        state_q;
    logic          we_q;
    logic [AW-1:0] adr_q;
    logic [DW-1:0] dat_q;
    logic [LW-1:0] cnt_q;
    logic          last_q;
    logic          stb_q;
    logic          busy_q;
    logic          done_q;
    logic [DW-1:0] rd_dat_q;
    logic          rd_vld_q;
    logic          can_issue;

    // A read can always be issued; a write waits for stream data.
    assign can_issue = !we_q || bus.WR_VLD_I;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int unsigned TW = (TMO > 1) ? $clog2(TMO) : 1;
    logic [TW-1:0] tmo_q;
    logic          err_q;
`endif

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            cnt_q    <= '0;
            last_q   <= 1'b0;
            stb_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_dat_q <= '0;
            rd_vld_q <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            done_q   <= 1'b0;
            rd_vld_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.START_I) begin
                        we_q    <= bus.WRITE_I;
                        adr_q   <= bus.BASE_I;
                        cnt_q   <= bus.LEN_I;
                        busy_q  <= 1'b1;
                        state_q <= S_REQ;
`ifdef WB_MASTER_TIMEOUT_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                S_REQ: begin
                    if (can_issue) begin
                        stb_q   <= 1'b1;
                        dat_q   <= we_q ? bus.WR_DAT_I : dat_q;
                        state_q <= S_WAIT;
`ifdef WB_MASTER_TIMEOUT_EN
                        tmo_q   <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (bus.ACK_I) begin
                        stb_q   <= 1'b0;
                        adr_q   <= adr_q + 1'b1;
                        cnt_q   <= cnt_q - 1'b1;
                        last_q  <= (cnt_q == '0);
                        state_q <= S_GAP;
                        if (!we_q) begin
                            rd_dat_q <= bus.DAT_I;
                            rd_vld_q <= 1'b1;
                        end
                    end
`ifdef WB_MASTER_TIMEOUT_EN
                    else if (tmo_q == TW'(TMO - 1)) begin
                        // Abandon the whole command; the stalled beat is not reported.
                        stb_q   <= 1'b0;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                S_GAP: begin
                    // The GAP cycle doubles as the request slot for the next beat.
                    if (last_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (can_issue) begin
                        stb_q   <= 1'b1;
                        dat_q   <= we_q ? bus.WR_DAT_I : dat_q;
                        state_q <= S_WAIT;
`ifdef WB_MASTER_TIMEOUT_EN
                        tmo_q   <= '0;
`endif
                    end else begin
                        state_q <= S_REQ;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.BUSY_O   = busy_q;
    assign bus.DONE_O   = done_q;
    assign bus.WR_RDY_O = (state_q == S_WAIT) && stb_q && we_q && bus.ACK_I;
    assign bus.RD_DAT_O = rd_dat_q;
    assign bus.RD_VLD_O = rd_vld_q;
    assign bus.ADR_O    = adr_q;
    assign bus.DAT_O    = dat_q;
    assign bus.WE_O     = stb_q && we_q;
    assign bus.STB_O    = stb_q;
    assign bus.CYC_O    = stb_q;
    assign DBG_STATE_O  = state_q;

`ifdef WB_MASTER_TIMEOUT_EN
    assign bus.ERR_O = err_q;
`else
    // TMO has no effect without the watchdog.
    localparam logic TmoSet = (TMO != 0);
    assign bus.ERR_O = TmoSet & 1'b0;
`endif
endmodule

// File: tb/tb_wb_block_master.sv
// Directed bench for wb_block_master against a behavioural 8 x 32 block-RAM Wishbone slave.
module tb_wb_block_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    wb_block_master_if #(.AW(3), .DW(32), .LW(3)) bus();
    logic [2:0] dbg_state;

    wb_block_master #(.AW(3), .DW(32), .LW(3), .TMO(15)) dut (
        .CLK_I       (clk),
        .RST_I       (rst),
        .bus         (bus),
        .DBG_STATE_O (dbg_state)
    );

    // Slave model: registered ACK one cycle after STB, never on back-to-back cycles.
    logic [31:0] mem [8];
    logic        ack_q = 1'b0;
    logic [31:0] sdat_q = '0;
    logic        mem_init = 1'b0;
    logic        ack_en = 1'b1;

    always @(posedge clk) begin
        if (rst) begin
            ack_q  <= 1'b0;
            sdat_q <= '0;
            if (!mem_init) begin
                for (int i = 0; i < 8; i++) mem[i] <= 32'h100 + 32'(i);
                mem_init <= 1'b1;
            end
        end else if (ack_en && bus.STB_O && bus.CYC_O && !ack_q) begin
            ack_q <= 1'b1;
            if (bus.WE_O) mem[bus.ADR_O] <= bus.DAT_O;
            sdat_q <= mem[bus.ADR_O];
        end else begin
            ack_q <= 1'b0;
        end
    end
    assign bus.ACK_I = ack_q;
    assign bus.DAT_I = sdat_q;

    // Write stream source: advances on every consumed beat.
    logic        wr_load = 1'b0;
    logic [31:0] wr_load_val = '0;
    logic [31:0] wr_data = '0;
    always @(posedge clk) begin
        if (wr_load) wr_data <= wr_load_val;
        else if (bus.WR_RDY_O) wr_data <= wr_data + 32'd1;
    end
    assign bus.WR_DAT_I = wr_data;

    // Monitor
    logic [31:0] exp_q[$];
    logic [31:0] adr_log[$];
    logic [31:0] wdat_log[$];
    logic [31:0] rd_log[$];
    int          rd_cyc_log[$];
    int          cyc_n = 0;
    int          done_cnt = 0;
    int          wr_rdy_cnt = 0;
    int          gap_viol = 0;
    int          cyc_viol = 0;
    logic        stb_prev = 1'b0;
    logic        ack_stb_prev = 1'b0;

    always @(negedge clk) begin
        cyc_n++;
        if (bus.STB_O && !stb_prev) adr_log.push_back(32'(bus.ADR_O));
        if (bus.WR_RDY_O) begin
            wdat_log.push_back(bus.DAT_O);
            wr_rdy_cnt++;
        end
        if (bus.RD_VLD_O) begin
            rd_log.push_back(bus.RD_DAT_O);
            rd_cyc_log.push_back(cyc_n);
        end
        if (bus.DONE_O) done_cnt++;
        if (ack_stb_prev && bus.STB_O) gap_viol++;
        if (bus.CYC_O !== bus.STB_O) cyc_viol++;
        stb_prev = bus.STB_O;
        ack_stb_prev = bus.STB_O && bus.ACK_I;
    end

    // Driver tasks (all drive #1 after a rising edge)
    task automatic clear_logs();
        adr_log.delete();
        wdat_log.delete();
        rd_log.delete();
        rd_cyc_log.delete();
        exp_q.delete();
        done_cnt = 0;
        wr_rdy_cnt = 0;
        gap_viol = 0;
        cyc_viol = 0;
    endtask

    task automatic load_wr(input logic [31:0] v);
        @(posedge clk); #1;
        wr_load = 1'b1;
        wr_load_val = v;
        @(posedge clk); #1;
        wr_load = 1'b0;
    endtask

    task automatic do_start(input logic w, input logic [2:0] base, input logic [2:0] len);
        @(posedge clk); #1;
        bus.START_I = 1'b1;
        bus.WRITE_I = w;
        bus.BASE_I = base;
        bus.LEN_I = len;
        @(posedge clk); #1;
        bus.START_I = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        ok = (done_cnt != 0);
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.START_I = 1'b0;
        bus.WRITE_I = 1'b0;
        bus.BASE_I = '0;
        bus.LEN_I = '0;
        bus.WR_VLD_I = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.STB_O, bus.CYC_O, bus.WE_O, bus.BUSY_O, bus.DONE_O, bus.ERR_O,
             bus.WR_RDY_O, bus.RD_VLD_O} !== 8'h00) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000000", {bus.STB_O, bus.CYC_O, bus.WE_O,
                     bus.BUSY_O, bus.DONE_O, bus.ERR_O, bus.WR_RDY_O, bus.RD_VLD_O});
        end
        checks++;
        if (bus.ADR_O !== 3'd0 || bus.DAT_O !== 32'd0 || bus.RD_DAT_O !== 32'd0) begin
            failures++;
            $display("FAIL reset_data got adr=%0d dat=%h rd=%h exp=0", bus.ADR_O, bus.DAT_O, bus.RD_DAT_O);
        end
        checks++;
        if (dbg_state !== 3'd0) begin
            failures++;
            $display("FAIL reset_state got=%0d exp=0", dbg_state);
        end
        rst = 1'b0;
    endtask

    task automatic test_write_burst();
        bit ok;
        load_wr(32'hA0);
        bus.WR_VLD_I = 1'b1;
        clear_logs();
        do_start(1'b1, 3'd2, 3'd3);
        checks++;
        if (bus.BUSY_O !== 1'b1) begin
            failures++;
            $display("FAIL wr_busy got=%b exp=1", bus.BUSY_O);
        end
        wait_done(60, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wr_timeout got=no_done exp=done");
        end
        exp_q = '{32'd2, 32'd3, 32'd4, 32'd5};
        checks++;
        if (adr_log.size() != 4) begin
            failures++;
            $display("FAIL wr_adr_count got=%0d exp=4", adr_log.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (adr_log[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL wr_adr[%0d] got=%0d exp=%0d", i, adr_log[i], exp_q[i]);
                end
            end
        end
        exp_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        checks++;
        if (wdat_log.size() != 4 || wr_rdy_cnt != 4) begin
            failures++;
            $display("FAIL wr_rdy_count got=%0d exp=4", wr_rdy_cnt);
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (wdat_log[i] !== exp_q[i] || mem[i + 2] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL wr_dat[%0d] got=%h mem=%h exp=%h", i, wdat_log[i], mem[i + 2], exp_q[i]);
                end
            end
        end
        checks++;
        if (done_cnt != 1 || gap_viol != 0 || cyc_viol != 0 || bus.BUSY_O !== 1'b0) begin
            failures++;
            $display("FAIL wr_protocol got done=%0d gap=%0d cyc=%0d busy=%b exp done=1 gap=0 cyc=0 busy=0",
                     done_cnt, gap_viol, cyc_viol, bus.BUSY_O);
        end
    endtask

    task automatic test_read_back();
        bit ok;
        bus.WR_VLD_I = 1'b0;
        clear_logs();
        do_start(1'b0, 3'd2, 3'd3);
        wait_done(60, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rd_timeout got=no_done exp=done");
        end
        exp_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        checks++;
        if (rd_log.size() != 4) begin
            failures++;
            $display("FAIL rd_count got=%0d exp=4", rd_log.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (rd_log[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL rd_dat[%0d] got=%h exp=%h", i, rd_log[i], exp_q[i]);
                end
            end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (rd_cyc_log[i] - rd_cyc_log[i - 1] != 3) begin
                    failures++;
                    $display("FAIL rd_spacing[%0d] got=%0d exp=3", i, rd_cyc_log[i] - rd_cyc_log[i - 1]);
                end
            end
        end
        checks++;
        if (done_cnt != 1 || gap_viol != 0 || cyc_viol != 0) begin
            failures++;
            $display("FAIL rd_protocol got done=%0d gap=%0d cyc=%0d exp done=1 gap=0 cyc=0",
                     done_cnt, gap_viol, cyc_viol);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        clear_logs();
        do_start(1'b0, 3'd6, 3'd3);
        wait_done(60, ok);
        exp_q = '{32'd6, 32'd7, 32'd0, 32'd1};
        checks++;
        if (!ok || adr_log.size() != 4 || rd_log.size() != 4) begin
            failures++;
            $display("FAIL wrap_count got done=%b adr=%0d rd=%0d exp done=1 adr=4 rd=4",
                     ok, adr_log.size(), rd_log.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (adr_log[i] !== exp_q[i] || rd_log[i] !== 32'h100 + exp_q[i]) begin
                    failures++;
                    $display("FAIL wrap_beat[%0d] got adr=%0d dat=%h exp adr=%0d dat=%h",
                             i, adr_log[i], rd_log[i], exp_q[i], 32'h100 + exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_write_stall();
        bit ok;
        int stb_seen = 0;
        load_wr(32'hB0);
        bus.WR_VLD_I = 1'b0;
        clear_logs();
        do_start(1'b1, 3'd0, 3'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.STB_O) stb_seen++;
            if (i == 1) begin
                bus.START_I = 1'b1;
                bus.WRITE_I = 1'b0;
                bus.BASE_I = 3'd5;
                bus.LEN_I = 3'd7;
            end
            if (i == 2) bus.START_I = 1'b0;
        end
        checks++;
        if (stb_seen != 0 || bus.BUSY_O !== 1'b1) begin
            failures++;
            $display("FAIL stall_idle got stb_cycles=%0d busy=%b exp stb_cycles=0 busy=1", stb_seen, bus.BUSY_O);
        end
        bus.WR_VLD_I = 1'b1;
        wait_done(60, ok);
        bus.WR_VLD_I = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        exp_q = '{32'd0, 32'd1};
        checks++;
        if (!ok || adr_log.size() != 2 || wdat_log.size() != 2 || done_cnt != 1 || bus.BUSY_O !== 1'b0) begin
            failures++;
            $display("FAIL stall_count got adr=%0d wr=%0d done=%0d busy=%b exp adr=2 wr=2 done=1 busy=0",
                     adr_log.size(), wdat_log.size(), done_cnt, bus.BUSY_O);
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (adr_log[i] !== exp_q[i] || wdat_log[i] !== 32'hB0 + exp_q[i] || mem[i] !== 32'hB0 + exp_q[i]) begin
                    failures++;
                    $display("FAIL stall_beat[%0d] got adr=%0d dat=%h mem=%h exp adr=%0d dat=%h",
                             i, adr_log[i], wdat_log[i], mem[i], exp_q[i], 32'hB0 + exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit found = 1'b0;
        clear_logs();
        do_start(1'b0, 3'd0, 3'd3);
        for (int i = 0; i < 30 && !found; i++) begin
            @(posedge clk); #1;
            if (bus.STB_O && bus.ADR_O == 3'd1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL rstmid_reach got=no_beat2 exp=beat2");
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (bus.STB_O !== 1'b0 || bus.BUSY_O !== 1'b0 || bus.RD_VLD_O !== 1'b0 || bus.DONE_O !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_outs got stb=%b busy=%b rdv=%b done=%b exp 0000",
                     bus.STB_O, bus.BUSY_O, bus.RD_VLD_O, bus.DONE_O);
        end
        clear_logs();
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != 0 || rd_log.size() != 0 || adr_log.size() != 0) begin
            failures++;
            $display("FAIL rstmid_quiet got done=%0d rd=%0d stb_starts=%0d exp 0",
                     done_cnt, rd_log.size(), adr_log.size());
        end
        do_start(1'b0, 3'd2, 3'd1);
        wait_done(40, ok);
        checks++;
        if (!ok || done_cnt != 1 || rd_log.size() != 2) begin
            failures++;
            $display("FAIL rstmid_fresh got done=%0d rd=%0d exp done=1 rd=2", done_cnt, rd_log.size());
        end else if (rd_log[0] !== 32'hA0 || rd_log[1] !== 32'hA1) begin
            failures++;
            $display("FAIL rstmid_fresh_dat got=%h,%h exp=a0,a1", rd_log[0], rd_log[1]);
        end
    endtask

`ifdef WB_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        bit seen_done = 1'b0;
        int stb_cycles = 0;
        ack_en = 1'b0;
        clear_logs();
        do_start(1'b0, 3'd4, 3'd2);
        for (int i = 0; i < 60 && !seen_done; i++) begin
            @(posedge clk); #1;
            if (bus.STB_O) stb_cycles++;
            if (bus.DONE_O) seen_done = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (!seen_done || stb_cycles != 15) begin
            failures++;
            $display("FAIL tmo_len got done=%b stb_cycles=%0d exp done=1 stb_cycles=15", seen_done, stb_cycles);
        end
        checks++;
        if (bus.ERR_O !== 1'b1 || done_cnt != 1 || rd_log.size() != 0 || bus.BUSY_O !== 1'b0) begin
            failures++;
            $display("FAIL tmo_state got err=%b done=%0d rd=%0d busy=%b exp err=1 done=1 rd=0 busy=0",
                     bus.ERR_O, done_cnt, rd_log.size(), bus.BUSY_O);
        end
        ack_en = 1'b1;
        clear_logs();
        do_start(1'b0, 3'd4, 3'd0);
        checks++;
        if (bus.ERR_O !== 1'b0) begin
            failures++;
            $display("FAIL tmo_clear got err=%b exp=0", bus.ERR_O);
        end
        wait_done(40, ok);
        checks++;
        if (!ok || rd_log.size() != 1 || rd_log[0] !== 32'hA2) begin
            failures++;
            $display("FAIL tmo_recover got done=%b rd=%0d exp done=1 rd=1 dat=a2", ok, rd_log.size());
        end
    endtask
`endif

    initial begin
        bus.START_I = 1'b0;
        bus.WRITE_I = 1'b0;
        bus.BASE_I = '0;
        bus.LEN_I = '0;
        bus.WR_VLD_I = 1'b0;
        test_reset();
        test_write_burst();
        test_read_back();
        test_wrap();
        test_write_stall();
        test_reset_mid();
`ifdef WB_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
